// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives a 1-cycle synchronous instruction memory and
// hands {pc, instr} to decode through a small skid buffer with redirect flush.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [31:0]     instr_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1) + 1;

    logic [XLEN-1:0] pc, inflight_pc, target;
    logic            inflight, pop, push, issue;
    logic [XLEN-1:0] buf_pc    [BUF_DEPTH];
    logic [XLEN-1:0] buf_instr [BUF_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        target    = redirect_pc & ~XLEN'(3);
        out_valid = (count != '0) & !redirect_valid;
        pop       = out_valid & out_ready;
        push      = inflight & !redirect_valid;
        // occupancy after this cycle counts the word still coming back from memory
        occ       = count + CW'(inflight) - CW'(pop);
        issue     = !rst & !redirect_valid & (occ < CW'(BUF_DEPTH));
        imem_addr = pc;
        out_pc    = buf_pc[head];
        out_instr = buf_instr[head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            instr_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc       <= target;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + XLEN'(4);
            end
            if (push) begin
                buf_pc[tail]    <= inflight_pc;
                buf_instr[tail] <= imem_data;
                tail            <= nxt(tail);
            end
            if (pop) begin
                head        <= nxt(head);
                instr_count <= instr_count + 32'd1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a 1-cycle read memory
// whose word at address a is 32'hA000_0000 | a.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_data, redirect_pc = '0;
    logic        redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_instr, instr_count;
    logic [31:0] sb [$];
    logic [31:0] exp_cnt = '0;
    logic [31:0] e;
    int          tests = 0, fails = 0;
    bit          go = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= 32'hA000_0000 | imem_addr;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] p);
        sb.delete();
        for (int k = 0; k < 64; k++) sb.push_back(p + 32'(4 * k));
    endtask

    // inputs for one cycle are applied just after the edge, checks follow 3ns later
    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy, input logic r);
        @(posedge clk);
        #1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        rst            = r;
        if (r) push_stream(32'h0);
        else if (rv) push_stream({rpc[31:2], 2'b00});
        #3;
    endtask

    always @(negedge clk) begin
        if (go) begin
            check("instr_count", instr_count, exp_cnt);
            if (rst) exp_cnt = '0;
            else if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_instr", out_instr, 32'hA000_0000 | e);
                end
                exp_cnt = exp_cnt + 1;
            end
        end
    end

    initial begin
        // reset and basic latency
        cyc(0, 0, 1, 1);
        go = 1'b1;
        cyc(0, 0, 1, 1);
        check("rst_valid", out_valid, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_cnt", instr_count, 0);
        cyc(0, 0, 1, 0);
        check("lat_t0", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("lat_t1", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("lat_t2", out_valid, 1);
        check("lat_pc", out_pc, 32'h0);
        cyc(0, 0, 1, 0);
        check("stream1", out_valid, 1);
        cyc(0, 0, 1, 0);
        check("stream2", out_valid, 1);
        cyc(0, 0, 0, 0);
        check("cnt3", instr_count, 3);

        // backpressure from reset
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_pc", out_pc, 32'h0);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0);
            check("bp_release", out_valid, 1);
            check("bp_seq", out_pc, 32'(4 * i));
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

        // redirect while streaming, misaligned target
        cyc(1, 32'h43, 1, 0);
        check("rd_t0", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("rd_t1", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("rd_t2", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("rd_t3", out_valid, 1);
        check("rd_pc", out_pc, 32'h40);
        check("rd_instr", out_instr, 32'hA000_0040);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

        // full buffer, redirect and ready together
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check("full_valid", out_valid, 1);
        cyc(1, 32'h100, 1, 0);
        check("full_rd_valid", out_valid, 0);
        cyc(0, 0, 1, 0);
        check("full_rd_t1", out_valid, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("full_rd_pc", out_pc, 32'h100);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

        // address wrap
        cyc(1, 32'hFFFF_FFF8, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);

        // reset mid-stream with a full buffer
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_addr", imem_addr, 32'h0);
        check("mrst_cnt", instr_count, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("mrst_restart", out_pc, 32'h0);
        check("mrst_rvalid", out_valid, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        @(posedge clk);
        go = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
